// File: rtl/apb_master.sv
// APB initiator: accepts single-beat read/write commands and drives SETUP/ACCESS
// to the responder. A one-cycle response pulse returns read data or a timeout flag.
module apb_master #(
    parameter int BITWIDTH  = 8,
    parameter int ADDRWIDTH = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic [BITWIDTH-1:0]  cmd_wdata,
    output logic                 rsp_valid,
    output logic [BITWIDTH-1:0]  rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 psel,
    output logic                 penable,
    output logic                 pwrite,
    output logic [ADDRWIDTH-1:0] paddr,
    output logic [BITWIDTH-1:0]  pwdata,
    input  logic                 pready,
    input  logic [BITWIDTH-1:0]  prdata
);

    localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]        wait_cnt, wait_cnt_nxt;
    logic                 psel_nxt, penable_nxt, pwrite_nxt;
    logic [ADDRWIDTH-1:0] paddr_nxt;
    logic [BITWIDTH-1:0]  pwdata_nxt;
    logic                 rsp_valid_nxt, rsp_err_nxt;
    logic [BITWIDTH-1:0]  rsp_rdata_nxt;
    logic                 timeout_hit;

    assign cmd_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == LAST) && !pready;

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (pready || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        psel_nxt      = psel;
        penable_nxt   = penable;
        pwrite_nxt    = pwrite;
        paddr_nxt     = paddr;
        pwdata_nxt    = pwdata;
        wait_cnt_nxt  = wait_cnt;
        rsp_valid_nxt = 1'b0;
        rsp_err_nxt   = 1'b0;
        rsp_rdata_nxt = '0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    psel_nxt    = 1'b1;
                    penable_nxt = 1'b0;
                    pwrite_nxt  = cmd_write;
                    paddr_nxt   = cmd_addr;
                    if (cmd_write) pwdata_nxt = cmd_wdata;
                end
            end
            SETUP: begin
                penable_nxt  = 1'b1;
                wait_cnt_nxt = '0;
            end
            ACCESS: begin
                if (pready) begin
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = pwrite ? '0 : prdata;
                end else if (timeout_hit) begin
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                end else if (wait_cnt != '1) begin
                    // Saturates so a disabled timeout cannot wrap the counter.
                    wait_cnt_nxt = wait_cnt + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            wait_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            psel      <= psel_nxt;
            penable   <= penable_nxt;
            pwrite    <= pwrite_nxt;
            paddr     <= paddr_nxt;
            pwdata    <= pwdata_nxt;
            wait_cnt  <= wait_cnt_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_err   <= rsp_err_nxt;
            rsp_rdata <= rsp_rdata_nxt;
        end
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB initiator (requester) for the UART register block.
- Takes single-beat read/write commands from a local controller (CPU shim, test sequencer) over a valid/ready command port.
- Runs the APB SETUP→ACCESS sequence, waits on pready, and returns a one-cycle response pulse carrying read data or an error flag.
- Includes a bounded wait-state timeout so a hung responder cannot stall the controller.

Parameters:
BITWIDTH, 8, width of pwdata/prdata and command/response data
ADDRWIDTH, 2, width of paddr (4 UART registers: 0 baud, 1 ctrl, 2 tx data, 3 rx data)
TIMEOUT, 16, max ACCESS cycles with pready low before abort; 0 disables timeout

Ports:
pclk  input  1  clock; all state updates on rising edge
presetn  input  1  reset, synchronous, active-low
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid&cmd_ready at a rising edge
cmd_write  input  1  1=write, 0=read
cmd_addr  input  ADDRWIDTH  register address
cmd_wdata  input  BITWIDTH  write data
rsp_valid  output  1  one-cycle response pulse, no backpressure
rsp_rdata  output  BITWIDTH  read data (0 for writes and errors)
rsp_err  output  1  qualified by rsp_valid; 1=timeout abort
busy  output  1  high in SETUP or ACCESS
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
paddr  output  ADDRWIDTH  APB address
pwdata  output  BITWIDTH  APB write data
pready  input  1  responder ready
prdata  input  BITWIDTH  responder read data

Behaviour:
- Clock and reset: one clock pclk; reset presetn is synchronous and active-low. At any rising edge with presetn=0, all registers go to reset values regardless of state.
- Reset values: state=IDLE; psel=0, penable=0, pwrite=0, paddr=0, pwdata=0; rsp_valid=0, rsp_rdata=0, rsp_err=0; wait counter=0.
- Combinational outputs: cmd_ready = (state==IDLE); busy = (state!=IDLE).
- A command is accepted only at an edge with presetn=1.
- IDLE→SETUP: at edge E0 with cmd_valid&cmd_ready, latch cmd_addr/cmd_write/cmd_wdata into paddr/pwrite/pwdata and set psel=1, penable=0. If cmd_write=0, pwdata holds its previous value.
- SETUP→ACCESS: unconditional at the next edge E1; penable=1, wait counter cleared. pready is ignored in SETUP.
- ACCESS, pready=1 sampled at an edge:
  - Set psel=0, penable=0; state→IDLE; rsp_valid=1 for exactly one cycle; rsp_err=0.
  - rsp_rdata = prdata for a read, 0 for a write.
- ACCESS, pready=0: stay in ACCESS; wait counter +1.
- Timeout abort: if TIMEOUT≠0 and wait counter==TIMEOUT-1 with pready=0, abort: psel=0, penable=0, state→IDLE, rsp_valid=1, rsp_err=1, rsp_rdata=0. With pready stuck low, the abort occurs at edge E(1+TIMEOUT).
- Wait counter width: $clog2(TIMEOUT+1), minimum 1. It never wraps.
- Stable outputs: paddr/pwrite/pwdata hold constant from E0 until the next accepted command. Changes on cmd_* after acceptance are ignored.
- Latency and throughput:
  - Zero-wait transfer: rsp_valid high in the cycle after E2.
  - cmd_ready returns in that same cycle, so the next accept is E3 at the earliest. Minimum period is 3 cycles per transfer.
  - Each wait state adds 1 cycle.
- rsp_valid deasserts at the next edge unconditionally.
- Reset during SETUP/ACCESS: transfer dropped, no response pulse, APB outputs cleared at that edge.

Test Plan:
- Reset: hold presetn=0 for 3 edges with cmd_valid=1 → psel=penable=rsp_valid=0, paddr=0, no command accepted.
- Zero-wait write: cmd addr=0, wdata=0x1A, pready=1 → psel=1 after E0, penable=1 after E1, paddr=0/pwdata=0x1A/pwrite=1 stable; rsp_valid=1, rsp_err=0, rsp_rdata=0 after E2 for one cycle.
- Read with 3 wait states: addr=3, pready low for 3 ACCESS edges then high, prdata=0x5C → rsp_valid after E5, rsp_rdata=0x5C, busy high E0..E5.
- Timeout: TIMEOUT=16, pready stuck 0 → abort at E17: psel=penable=0, rsp_valid=1, rsp_err=1, rsp_rdata=0; a follow-up command is accepted normally.
- Back-to-back: cmd_valid held with 2 writes (addr 2 data 0x41, then 0x42), pready=1 → accepts at E0 and E3, two rsp_valid pulses 3 cycles apart, pwdata changes only at E3.
- Reset mid-ACCESS: presetn=0 at the edge after E1 while pready=0 → all outputs zero, no rsp_valid; after release, a read of addr 1 completes normally.
